// File: rtl/gs2rgb_tx_pkg.sv
// gs2rgb_tx_pkg
//   Shared definitions for the grayscale-to-RGB transmit path: pixel and byte
//   widths, the default pad byte, and the byte-select type that names which
//   byte of the current pixel is on the output (R first, then G, B, PAD).
//   No ports (package).
package gs2rgb_tx_pkg;

    localparam int PIX_W     = 8;   // gray pixel width
    localparam int BYTE_W    = 8;   // output byte width
    localparam int PIX_CNT_W = 16;  // width of the sent-pixel counter

    localparam logic [BYTE_W-1:0] DEFAULT_PAD_BYTE = 8'hFF;

    // Byte order within one transmitted pixel; the encoding doubles as the
    // phase counter value.
    typedef enum logic [1:0] {
        SEL_R   = 2'd0,
        SEL_G   = 2'd1,
        SEL_B   = 2'd2,
        SEL_PAD = 2'd3
    } byte_sel_e;

    // Next byte select after an accepted byte; wraps to R after the last
    // byte of the pixel.
    function automatic byte_sel_e next_sel(input byte_sel_e cur, input byte_sel_e last);
        byte_sel_e nxt;
        nxt = (cur == last) ? SEL_R : byte_sel_e'(cur + 2'd1);
        return nxt;
    endfunction

endpackage

// File: rtl/gs2rgb_tx_pix_fifo.sv
// pix_fifo
//   Small synchronous FIFO holding gray pixels between the strobe-only
//   producer and the byte serializer. Pointers use natural binary wrap, so
//   DEPTH must be a power of two.
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset (empties the FIFO)
//   push   in   write din at the tail (ignored when full unless popping)
//   pop    in   drop the head entry (ignored when empty)
//   din    in   WIDTH  data to write
//   dout   out  WIDTH  head entry (meaningful only when !empty)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  occupancy, $clog2(DEPTH)+1 bits
module pix_fifo
    import gs2rgb_tx_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = PIX_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign dout  = mem[rd_ptr];

    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/gs2rgb_tx.sv
// gs2rgb_tx
//   Transmit side of the grayscale path. Gray pixels arrive as single-cycle
//   strobes (no backpressure), are buffered in pix_fifo, and each one is
//   re-expanded into R=G=B=gs bytes (plus an optional pad byte) on a
//   valid/ready byte stream.
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   gs          in   8   gray pixel
//   gs_valid    in   1   gs valid this cycle (strobe)
//   gs_ready    out  1   FIFO has room (informational, from registered count)
//   byte_out    out  8   output byte (0 while empty / in reset)
//   byte_valid  out  1   byte_out valid
//   byte_ready  in   1   consumer accepts byte
//   overflow    out  1   sticky: a pixel was dropped on a full FIFO
//   pix_sent    out  16  pixels fully transmitted, wrapping
//
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
// byte_valid never drops and byte_out never changes while a byte is offered
// but not accepted; byte_ready while byte_valid=0 has no effect.
module gs2rgb_tx
    import gs2rgb_tx_pkg::*;
#(
    parameter int                FIFO_DEPTH      = 4,
    parameter int                BYTES_PER_PIXEL = 3,
    parameter logic [BYTE_W-1:0] PAD_BYTE        = DEFAULT_PAD_BYTE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIX_W-1:0]     gs,
    input  logic                 gs_valid,
    output logic                 gs_ready,
    output logic [BYTE_W-1:0]    byte_out,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic                 overflow,
    output logic [PIX_CNT_W-1:0] pix_sent
);

    localparam int        AW       = $clog2(FIFO_DEPTH);
    localparam int        CW       = AW + 1;
    localparam byte_sel_e LAST_SEL = byte_sel_e'(2'(BYTES_PER_PIXEL - 1));

    if (BYTES_PER_PIXEL != 3 && BYTES_PER_PIXEL != 4) begin : g_bad_bpp
        $error("gs2rgb_tx: BYTES_PER_PIXEL must be 3 or 4");
    end
    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
        $error("gs2rgb_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [PIX_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    byte_sel_e        phase;
    logic             byte_acc;
    logic             pix_done;

    assign byte_valid = !fifo_empty;
    assign byte_acc   = byte_valid && byte_ready;
    // Last byte of the head pixel accepted: pop it and count it as sent.
    assign pix_done   = byte_acc && (phase == LAST_SEL);
    assign gs_ready   = (fifo_count < CW'(FIFO_DEPTH));

    // Forced to zero when nothing is buffered so reset shows a clean 0
    // even though FIFO storage itself is not reset.
    assign byte_out = fifo_empty         ? '0 :
                      (phase == SEL_PAD) ? PAD_BYTE :
                                           BYTE_W'(head);

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (gs_valid),
        .pop   (pix_done),
        .din   (gs),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= SEL_R;
            overflow <= 1'b0;
            pix_sent <= '0;
        end else begin
            if (byte_acc) phase <= next_sel(phase, LAST_SEL);
            if (pix_done) pix_sent <= pix_sent + 1'b1;
            // A push on a full FIFO is only lost when no pop frees a slot.
            if (gs_valid && fifo_full && !pix_done) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gs2rgb_tx.sv
module tb_gs2rgb_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [7:0]  gs3 = '0, gs4 = '0;
  logic        gv3 = 1'b0, gv4 = 1'b0;
  logic        br3 = 1'b0, br4 = 1'b0;
  logic        gr3, gr4, bv3, bv4, ov3, ov4;
  logic [7:0]  bo3, bo4;
  logic [15:0] ps3, ps4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gs2rgb_tx #(.FIFO_DEPTH(4), .BYTES_PER_PIXEL(3), .PAD_BYTE(8'hFF)) dut3 (
    .clk(clk), .rst(rst), .gs(gs3), .gs_valid(gv3), .gs_ready(gr3),
    .byte_out(bo3), .byte_valid(bv3), .byte_ready(br3),
    .overflow(ov3), .pix_sent(ps3)
  );

  gs2rgb_tx #(.FIFO_DEPTH(4), .BYTES_PER_PIXEL(4), .PAD_BYTE(8'hFF)) dut4 (
    .clk(clk), .rst(rst), .gs(gs4), .gs_valid(gv4), .gs_ready(gr4),
    .byte_out(bo4), .byte_valid(bv4), .byte_ready(br4),
    .overflow(ov4), .pix_sent(ps4)
  );

  // ---------------- clock / reset helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    gv3 = 1'b0; gv4 = 1'b0; br3 = 1'b0; br4 = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- directed vector table (BPP=3 instance) ----------------
  typedef struct {
    bit         do_rst;
    bit         gv;
    logic [7:0] gs;
    bit         br;
    bit         e_v;
    logic [7:0] e_b;
    bit         e_gr;
    bit         e_ov;
    int         e_ps;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit gv, logic [7:0] g, bit br,
                              bit ev, logic [7:0] eb, bit egr, bit eov, int eps);
    vec_t v;
    v.do_rst = r; v.gv = gv; v.gs = g; v.br = br;
    v.e_v = ev; v.e_b = eb; v.e_gr = egr; v.e_ov = eov; v.e_ps = eps;
    tbl.push_back(v);
  endfunction

  function automatic void build_table();
    logic [7:0] pix4[4];
    logic [7:0] pix3[4];
    logic [7:0] br_seq[5];
    pix4 = '{8'd2, 8'd3, 8'd4, 8'd5};
    pix3 = '{8'd10, 8'd20, 8'd30, 8'd40};
    br_seq = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1};
    // single pixel, byte_ready held high
    add(1, 1, 8'd122, 1, 0, 8'd0, 1, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 8'd0, 1, 1, 8'd122, 1, 0, 0);
    add(0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 1);
    // backpressure: ready pattern 1,0,0,1,1 consumes exactly three bytes
    add(1, 1, 8'd64, 0, 0, 8'd0, 1, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 8'd0, br_seq[k][0], 1, 8'd64, 1, 0, 0);
    add(0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 1);
    // full FIFO with push on the cycle the head's last byte is accepted
    add(1, 1, 8'd1, 0, 0, 8'd0, 1, 0, 0);
    add(0, 1, 8'd2, 0, 1, 8'd1, 1, 0, 0);
    add(0, 1, 8'd3, 0, 1, 8'd1, 1, 0, 0);
    add(0, 1, 8'd4, 0, 1, 8'd1, 1, 0, 0);
    add(0, 0, 8'd0, 1, 1, 8'd1, 0, 0, 0);
    add(0, 0, 8'd0, 1, 1, 8'd1, 0, 0, 0);
    add(0, 1, 8'd5, 1, 1, 8'd1, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) add(0, 0, 8'd0, 1, 1, pix4[i], (i > 0), 0, 1 + i);
    add(0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 5);
    // overflow: five pulses into a depth-4 FIFO while stalled
    add(1, 1, 8'd10, 0, 0, 8'd0, 1, 0, 0);
    add(0, 1, 8'd20, 0, 1, 8'd10, 1, 0, 0);
    add(0, 1, 8'd30, 0, 1, 8'd10, 1, 0, 0);
    add(0, 1, 8'd40, 0, 1, 8'd10, 1, 0, 0);
    add(0, 1, 8'd50, 0, 1, 8'd10, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) add(0, 0, 8'd0, 1, 1, pix3[i], (i > 0), 1, i);
    add(0, 0, 8'd0, 1, 0, 8'd0, 1, 1, 4);
  endfunction

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].do_rst) do_reset();
      check($sformatf("tbl%0d_valid", i), bv3, tbl[i].e_v);
      if (tbl[i].e_v) check($sformatf("tbl%0d_byte", i), bo3, tbl[i].e_b);
      check($sformatf("tbl%0d_gs_ready", i), gr3, tbl[i].e_gr);
      check($sformatf("tbl%0d_overflow", i), ov3, tbl[i].e_ov);
      check($sformatf("tbl%0d_pix_sent", i), ps3, tbl[i].e_ps);
      gv3 = tbl[i].gv; gs3 = tbl[i].gs; br3 = tbl[i].br;
      tick();
    end
    gv3 = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] exp_q[$];
  int         m_phase;
  bit         m_ovf;
  int         m_sent;

  function automatic void model_reset();
    exp_q.delete();
    m_phase = 0; m_ovf = 0; m_sent = 0;
  endfunction

  // One clock edge: a transmitted pixel is bpp accepted bytes; a strobe is
  // stored if there is room after any pop, otherwise lost.
  function automatic void model_edge(int bpp, bit gv, logic [7:0] g, bit br);
    if (exp_q.size() != 0 && br) begin
      m_phase++;
      if (m_phase == bpp) begin
        m_phase = 0;
        void'(exp_q.pop_front());
        m_sent = (m_sent + 1) % 65536;
      end
    end
    if (gv) begin
      if (exp_q.size() < 4) exp_q.push_back(g);
      else m_ovf = 1;
    end
  endfunction

  task automatic run_random(input int d, input int ncyc);
    int         bpp;
    bit         gv, br;
    logic [7:0] g, e_b;
    logic       a_v, a_gr, a_ov;
    logic [7:0] a_b;
    logic [15:0] a_ps;
    bpp = (d == 0) ? 3 : 4;
    do_reset();
    model_reset();
    for (int c = 0; c < ncyc; c++) begin
      if (d == 0) begin a_v = bv3; a_b = bo3; a_gr = gr3; a_ov = ov3; a_ps = ps3; end
      else        begin a_v = bv4; a_b = bo4; a_gr = gr4; a_ov = ov4; a_ps = ps4; end
      check($sformatf("rnd%0d_c%0d_valid", bpp, c), a_v, (exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e_b = (m_phase == 3) ? 8'hFF : exp_q[0];
        check($sformatf("rnd%0d_c%0d_byte", bpp, c), a_b, e_b);
      end
      check($sformatf("rnd%0d_c%0d_gs_ready", bpp, c), a_gr, (exp_q.size() < 4));
      check($sformatf("rnd%0d_c%0d_overflow", bpp, c), a_ov, m_ovf);
      check($sformatf("rnd%0d_c%0d_pix_sent", bpp, c), a_ps, m_sent);
      gv = ($urandom_range(99) < ((c < ncyc / 2) ? 25 : 60));
      br = ($urandom_range(99) < 75);
      g  = 8'($urandom_range(255));
      if (d == 0) begin gv3 = gv; gs3 = g; br3 = br; end
      else        begin gv4 = gv; gs4 = g; br4 = br; end
      model_edge(bpp, gv, g, br);
      tick();
    end
    gv3 = 1'b0; gv4 = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] exp5[4];
    exp5 = '{8'd210, 8'd210, 8'd210, 8'hFF};

    // reset state while rst is held
    #1;
    check("rst_valid", bv3, 1'b0);
    check("rst_gs_ready", gr3, 1'b1);
    check("rst_byte", bo3, 8'd0);
    check("rst_overflow", ov3, 1'b0);
    check("rst_pix_sent", ps3, 16'd0);

    build_table();
    run_table();

    // reset mid-pixel: state here is empty, overflow=1, pix_sent=4
    gv3 = 1'b1; gs3 = 8'd7; br3 = 1'b1;
    tick();
    gv3 = 1'b0;
    check("mid_b0", bo3, 8'd7);
    tick();
    check("mid_b1", bo3, 8'd7);
    tick();
    check("mid_b2_valid", bv3, 1'b1);
    check("mid_pre_pix_sent", ps3, 16'd4);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", bv3, 1'b0);
    check("mid_rst_pix_sent", ps3, 16'd0);
    check("mid_rst_overflow", ov3, 1'b0);
    check("mid_rst_gs_ready", gr3, 1'b1);
    check("mid_rst_byte", bo3, 8'd0);
    tick();
    rst = 1'b0;
    check("mid_after_valid", bv3, 1'b0);
    gv3 = 1'b1; gs3 = 8'd9;
    tick();
    gv3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mid_nine_valid%0d", k), bv3, 1'b1);
      check($sformatf("mid_nine_byte%0d", k), bo3, 8'd9);
      tick();
    end
    check("mid_end_valid", bv3, 1'b0);
    check("mid_end_pix_sent", ps3, 16'd1);

    // four bytes per pixel with pad
    do_reset();
    gv4 = 1'b1; gs4 = 8'd210; br4 = 1'b1;
    tick();
    gv4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bpp4_valid%0d", k), bv4, 1'b1);
      check($sformatf("bpp4_byte%0d", k), bo4, exp5[k]);
      check($sformatf("bpp4_pix_sent%0d", k), ps4, 16'd0);
      tick();
    end
    check("bpp4_end_valid", bv4, 1'b0);
    check("bpp4_end_pix_sent", ps4, 16'd1);

    // randomized traffic against the reference model
    run_random(0, 3000);
    run_random(1, 3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
